multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide responder for the pipelined processor; the processor's execute stage is the initiator.
- The processor issues a one-cycle ctrl_MULT or ctrl_DIV pulse with both operands, stalls, then consumes the result on the data_resultRDY pulse.
- Sits beside the ALU in execute; the stall and bypass logic live in the processor, not here.

---
 rtl/multdiv_pkg.sv | 28 ++
 rtl/multdiv_div_core.sv | 82 ++++++++
 rtl/multdiv_unit.sv | 164 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULTDIV_BOOTH4_EN selects radix-4 Booth multiply (WIDTH/2 iterations).
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  localparam int WIDTH_DEF = 32;

  function automatic int mul_steps(input int w);
`ifdef MULTDIV_BOOTH4_EN
    return w / 2;
`else
    return w;
`endif
  endfunction

  // Start edge to RDY edge, in clock edges
  localparam int MUL_LAT = mul_steps(WIDTH_DEF) + 1;
  localparam int DIV_LAT = WIDTH_DEF + 1;

  localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/multdiv_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step.
// Sign fix-up, divide-by-zero and INT_MIN/-1 handling are applied on the output.
module multdiv_div_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             exception
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    neg_d = neg_q;
    dz_d  = dz_q;
    ovf_d = ovf_q;

    partial = {rem_q, quo_q[WIDTH-1]};
    fits    = partial >= {1'b0, dvs_q};
    // When the divisor fits, the true difference is below 2^WIDTH, so the narrow subtract is exact
    diff    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} - dvs_q;

    if (load) begin
      rem_d = '0;
      quo_d = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_d = divisor[WIDTH-1] ? -divisor : divisor;
      neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dz_d  = (divisor == '0);
      ovf_d = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
    end else if (step) begin
      if (fits) begin
        rem_d = diff;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = partial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      neg_q <= neg_d;
      dz_q  <= dz_d;
      ovf_q <= ovf_d;
    end
  end

  // INT_MIN/-1 yields magnitude 2^(WIDTH-1) with positive sign, which already reads as INT_MIN
  assign quotient  = dz_q ? '0 : (neg_q ? -quo_q : quo_q);
  assign exception = dz_q | ovf_q;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (Booth) / divide (restoring) unit with start/RDY handshake.
// MULTDIV_BOOTH4_EN switches the multiplier to radix-4 modified Booth.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int MSTEPS = mul_steps(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(MSTEPS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_mul_q, op_mul_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             div_load, div_step;
  logic [WIDTH-1:0] div_quotient;
  logic             div_exception;

  // Booth step: {acc, mq, qm1} is the product register; acc carries two guard bits
  logic [WIDTH+1:0]   m_ext, addend, sum;
  logic [2*WIDTH+2:0] shifted;

  always_comb begin
    m_ext  = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    addend = '0;
`ifdef MULTDIV_BOOTH4_EN
    case ({mq_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum     = acc_q + addend;
    shifted = $signed({sum, mq_q, qm1_q}) >>> 2;
`else
    case ({mq_q[0], qm1_q})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
    sum     = acc_q + addend;
    shifted = $signed({sum, mq_q, qm1_q}) >>> 1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;

    // A start pulse in any state aborts whatever is running; MULT wins a tie
    if (ctrl_MULT) begin
      state_d  = ST_MUL;
      cnt_d    = '0;
      op_mul_d = 1'b1;
      mcand_d  = data_operandA;
      acc_d    = '0;
      mq_d     = data_operandB;
      qm1_d    = 1'b0;
    end else if (ctrl_DIV) begin
      state_d  = ST_DIV;
      cnt_d    = '0;
      op_mul_d = 1'b0;
      div_load = 1'b1;
    end else begin
      case (state_q)
        ST_MUL: begin
          {acc_d, mq_d, qm1_d} = shifted;
          if (cnt_q == MUL_LAST) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (cnt_q == DIV_LAST) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
          if (op_mul_q) begin
            result_d = mq_q;
            exc_d    = acc_q[WIDTH-1:0] != {WIDTH{mq_q[WIDTH-1]}};
          end else begin
            result_d = div_quotient;
            exc_d    = div_exception;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  multdiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (data_operandA),
    .divisor   (data_operandB),
    .quotient  (div_quotient),
    .exception (div_exception)
  );

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: arithmetic reference model plus literal directed cases.
module tb_multdiv_unit;
  import multdiv_pkg::*;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT_LIT = 17;
`else
  localparam int MUL_LAT_LIT = 33;
`endif
  localparam int DIV_LAT_LIT = 33;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  always #5 clock = ~clock;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain 64-bit signed multiply and truncating signed divide
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return {p != longint'($signed(p[31:0])), p[31:0]};
  endfunction

  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {1'b1, 32'h0};
    if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
    return {1'b0, 32'(sa / sb)};
  endfunction

  // Behavioural model: one pending operation, due a fixed number of edges after its start
  logic        pend = 1'b0;
  int          edge_n = 0;
  int          due = 0;
  logic [31:0] exp_res = '0;
  logic        exp_exc = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;
  logic        m_rdy = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      m_rdy <= 1'b0;
      m_res <= '0;
      m_exc <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      m_rdy  <= 1'b0;
      if (ctrl_MULT) begin
        pend <= 1'b1;
        due  <= edge_n + MUL_LAT;
        {exp_exc, exp_res} <= ref_mul(data_operandA, data_operandB);
      end else if (ctrl_DIV) begin
        pend <= 1'b1;
        due  <= edge_n + DIV_LAT;
        {exp_exc, exp_res} <= ref_div(data_operandA, data_operandB);
      end else if (pend && edge_n == due) begin
        pend  <= 1'b0;
        m_rdy <= 1'b1;
        m_res <= exp_res;
        m_exc <= exp_exc;
      end
    end
  end

  always @(negedge clock) begin
    chk("rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
    chk("result", data_result, m_res);
    chk("exception", {31'b0, data_exception}, {31'b0, m_exc});
  end

  task automatic pulse(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = mul;
    ctrl_DIV = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_lit(input string nm, input bit mul, input bit div,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] er, input logic ee);
    int n;
    pulse(mul, div, a, b);
    wait_rdy(n);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exception"}, {31'b0, data_exception}, {31'b0, ee});
    $display("op %s A=%h B=%h -> result=%h exc=%b latency=%0d", nm, a, b, data_result, data_exception, n);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return INT_MIN;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses, lat, n, d;
    logic [31:0] res_seen, a, b;
    bit mul, div;

    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;

    run_lit("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, MUL_LAT_LIT, 32'hFFFF_FFEB, 1'b0);
    run_lit("mul_2p16_sq", 1, 0, 32'h0001_0000, 32'h0001_0000, MUL_LAT_LIT, 32'h0, 1'b1);
    run_lit("mul_max_x2", 1, 0, 32'h7FFF_FFFF, 32'd2, MUL_LAT_LIT, 32'hFFFF_FFFE, 1'b1);
    run_lit("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, DIV_LAT_LIT, 32'hFFFF_FFFD, 1'b0);
    run_lit("div_100_7", 0, 1, 32'd100, 32'd7, DIV_LAT_LIT, 32'h0000_000E, 1'b0);
    run_lit("div_5_0", 0, 1, 32'd5, 32'd0, DIV_LAT_LIT, 32'h0, 1'b1);
    run_lit("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT_LIT, 32'h8000_0000, 1'b1);
    run_lit("both_6_3", 1, 1, 32'd6, 32'd3, MUL_LAT_LIT, 32'd18, 1'b0);

    // Restart: a MULT during a DIV aborts the divide; only the multiply completes
    pulse(0, 1, 32'd100, 32'd7);
    repeat (8) @(negedge clock);
    pulse(1, 0, 32'd6, 32'd7);
    pulses = 0;
    lat = -1;
    res_seen = '0;
    for (int i = 0; i < 70; i++) begin
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          lat = i;
          res_seen = data_result;
        end
      end
      @(negedge clock);
    end
    chk("restart_rdy_count", 32'(pulses), 32'd1);
    chk("restart_latency", 32'(lat), 32'(MUL_LAT_LIT));
    chk("restart_result", res_seen, 32'd42);
    $display("op restart DIV 100/7 -> MULT 6*7: rdy_pulses=%0d latency=%0d result=%h", pulses, lat, res_seen);

    // Reset mid-divide: no completion, outputs cleared
    pulse(0, 1, 32'd100, 32'd7);
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (data_resultRDY === 1'b1) pulses++;
      @(negedge clock);
    end
    chk("reset_abort_rdy_count", 32'(pulses), 32'd0);
    chk("reset_abort_result", data_result, 32'h0);
    chk("reset_abort_exception", {31'b0, data_exception}, 32'h0);
    $display("op reset-abort DIV 100/7: rdy_pulses=%0d result=%h exc=%b", pulses, data_result, data_exception);

    // Randomized operations, some aborted by the next start (including in the final cycle)
    for (int k = 0; k < 80; k++) begin
      a = pick();
      b = pick();
      mul = $urandom_range(0, 1) == 1;
      div = !mul || ($urandom_range(0, 7) == 0);
      pulse(mul, div, a, b);
      if ($urandom_range(0, 4) == 0) begin
        d = $urandom_range(1, 33);
        repeat (d) @(negedge clock);
        $display("op rand%0d %s A=%h B=%h aborted after %0d cycles", k, mul ? "MULT" : "DIV", a, b, d);
      end else begin
        wait_rdy(n);
        chk("rand_done", {31'b0, data_resultRDY}, 32'h1);
        $display("op rand%0d %s A=%h B=%h -> result=%h exc=%b latency=%0d",
                 k, mul ? "MULT" : "DIV", a, b, data_result, data_exception, n);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end

    repeat (40) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
